// File: rtl/labyrinth_pkg.sv
// Shared definitions for the labyrinth game: one-hot movement codes and the
// direction-state encoding used by the tilt encoder.
package labyrinth_pkg;

  localparam logic [3:0] DirNone  = 4'b0000;
  localparam logic [3:0] DirUp    = 4'b0001;
  localparam logic [3:0] DirDown  = 4'b0010;
  localparam logic [3:0] DirLeft  = 4'b0100;
  localparam logic [3:0] DirRight = 4'b1000;

  typedef enum logic [2:0] {
    StNone,
    StUp,
    StDown,
    StLeft,
    StRight
  } move_state_e;

  // One-hot movement code for a direction state.
  function automatic logic [3:0] dir_of(move_state_e st);
    logic [3:0] dir;
    dir = DirNone;
    case (st)
      StUp:    dir = DirUp;
      StDown:  dir = DirDown;
      StLeft:  dir = DirLeft;
      StRight: dir = DirRight;
      default: dir = DirNone;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/tilt_averager.sv
// Block averager for one accelerometer axis: sums 2^AVG_SHIFT signed samples
// and registers the floored mean, pulsing ready with the new value.
module tilt_averager #(
  parameter int unsigned ACC_WIDTH = 12,
  parameter int unsigned AVG_SHIFT = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [ACC_WIDTH-1:0] sample,
  input  logic                        valid,
  output logic signed [ACC_WIDTH-1:0] tilt,
  output logic                        ready
);

  localparam int unsigned SumW = ACC_WIDTH + AVG_SHIFT;
  localparam int unsigned CntW = AVG_SHIFT + 1;
  localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_SHIFT) - 1);

  logic signed [SumW-1:0]      acc_q;
  logic signed [SumW-1:0]      sum;
  logic [CntW-1:0]             cnt_q;
  logic signed [ACC_WIDTH-1:0] tilt_q;
  logic                        ready_q;

  // Running sum including the sample presented this cycle (sign-extended).
  assign sum = acc_q + SumW'(sample);

  // Accumulate samples; on the last one of a window publish the mean and restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      tilt_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (valid) begin
        if (cnt_q == CntLast) begin
          // Arithmetic shift floors toward minus infinity; the mean always fits.
          tilt_q  <= ACC_WIDTH'(sum >>> AVG_SHIFT);
          acc_q   <= '0;
          cnt_q   <= '0;
          ready_q <= 1'b1;
        end else begin
          acc_q <= sum;
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end
  end

  assign tilt  = tilt_q;
  assign ready = ready_q;

endmodule

// File: rtl/tilt_move_encoder.sv
// Turns averaged accelerometer tilt into a one-hot movement command with a
// dead-zone/hysteresis direction FSM, refreshed on a periodic update strobe.
module tilt_move_encoder
  import labyrinth_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY_HZ       = 100000000,
  parameter int unsigned UPDATE_FREQUENCY_HZ    = 30,
  parameter int unsigned CNTR_WIDTH             = 32,
  parameter int unsigned SIMULATE               = 0,
  parameter int unsigned SIMULATE_FREQUENCY_CNT = 5,
  parameter int unsigned ACC_WIDTH              = 12,
  parameter int unsigned AVG_SHIFT              = 2,
  parameter int unsigned DEAD_ZONE              = 100,
  parameter int unsigned HYST                   = 40
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [ACC_WIDTH-1:0] accel_x,
  input  logic signed [ACC_WIDTH-1:0] accel_y,
  input  logic                        accel_valid,
  output logic [3:0]                  movement,
  output logic                        update,
  output logic signed [ACC_WIDTH-1:0] tilt_x,
  output logic signed [ACC_WIDTH-1:0] tilt_y,
  output logic                        avg_ready
);

  localparam int unsigned Period = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                                   : CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ;
  localparam logic [CNTR_WIDTH-1:0] CntLast = CNTR_WIDTH'(Period - 1);

  // Two spare bits: one for |-2^(W-1)|, one to keep d + HYST from overflowing.
  localparam int unsigned CmpW = ACC_WIDTH + 2;
  localparam logic signed [CmpW-1:0] DeadZoneCmp = CmpW'(DEAD_ZONE);
  localparam logic signed [CmpW-1:0] HystCmp     = CmpW'(HYST);
  localparam logic signed [CmpW-1:0] EnterCmp    = CmpW'(DEAD_ZONE + HYST);

  logic ready_x, ready_y;

  tilt_averager #(
    .ACC_WIDTH(ACC_WIDTH),
    .AVG_SHIFT(AVG_SHIFT)
  ) u_avg_x (
    .clk   (clk),
    .reset (reset),
    .sample(accel_x),
    .valid (accel_valid),
    .tilt  (tilt_x),
    .ready (ready_x)
  );

  tilt_averager #(
    .ACC_WIDTH(ACC_WIDTH),
    .AVG_SHIFT(AVG_SHIFT)
  ) u_avg_y (
    .clk   (clk),
    .reset (reset),
    .sample(accel_y),
    .valid (accel_valid),
    .tilt  (tilt_y),
    .ready (ready_y)
  );

  // Both axes share the strobe, so their ready pulses coincide.
  assign avg_ready = ready_x & ready_y;

  move_state_e            state_q, state_d, cand;
  logic signed [CmpW-1:0] tx, ty, mx, my, strength, drive;
  logic                   y_dom, keep;

  assign tx = CmpW'(tilt_x);
  assign ty = CmpW'(tilt_y);

  // Direction state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StNone;
    end else begin
      state_q <= state_d;
    end
  end

  // Pick the dominant candidate and apply dead-zone/hysteresis once per window.
  always_comb begin
    mx       = tx[CmpW-1] ? -tx : tx;
    my       = ty[CmpW-1] ? -ty : ty;
    y_dom    = (my >= mx);
    strength = y_dom ? my : mx;
    cand     = y_dom ? (ty[CmpW-1] ? StUp : StDown) : (tx[CmpW-1] ? StLeft : StRight);

    drive = '0;
    case (state_q)
      StUp:    drive = -ty;
      StDown:  drive = ty;
      StLeft:  drive = -tx;
      StRight: drive = tx;
      default: drive = '0;
    endcase

    keep = (state_q != StNone) && (drive > DeadZoneCmp) &&
           !((cand != state_q) && (strength >= drive + HystCmp));

    state_d = state_q;
    if (avg_ready) begin
      if (keep) begin
        state_d = state_q;
      end else if (strength > EnterCmp) begin
        state_d = cand;
      end else begin
        state_d = StNone;
      end
    end
  end

  logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]            movement_q;
  logic                  update_q;

  assign cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CNTR_WIDTH'(1);

  // Prescaler: movement is loaded on entry to the terminal count so it is
  // already settled for a full cycle when update rises after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      movement_q <= DirNone;
      update_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      update_q <= (cnt_q == CntLast);
      if (cnt_d == CntLast) begin
        movement_q <= dir_of(state_q);
      end
    end
  end

  assign movement = movement_q;
  assign update   = update_q;

endmodule

// File: tb/tb_tilt_move_encoder.sv
// Self-checking bench for tilt_move_encoder with the simulation prescaler.
module tb_tilt_move_encoder;

  localparam int unsigned AccW = 12;
  localparam int          P    = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic signed [AccW-1:0] accel_x, accel_y;
  logic                   accel_valid;
  logic [3:0]             movement;
  logic                   update;
  logic signed [AccW-1:0] tilt_x, tilt_y;
  logic                   avg_ready;

  typedef struct {
    int x;
    int y;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         avg_cnt = 0;
  int         gap;
  logic [3:0] move_before;

  tilt_move_encoder #(
    .CLK_FREQUENCY_HZ      (100000000),
    .UPDATE_FREQUENCY_HZ   (30),
    .CNTR_WIDTH            (32),
    .SIMULATE              (1),
    .SIMULATE_FREQUENCY_CNT(5),
    .ACC_WIDTH             (12),
    .AVG_SHIFT             (2),
    .DEAD_ZONE             (100),
    .HYST                  (40)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .accel_x    (accel_x),
    .accel_y    (accel_y),
    .accel_valid(accel_valid),
    .movement   (movement),
    .update     (update),
    .tilt_x     (tilt_x),
    .tilt_y     (tilt_y),
    .avg_ready  (avg_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (avg_ready === 1'b1) avg_cnt <= avg_cnt + 1;
  end

  task automatic send_sample(input int x, input int y);
    @(posedge clk);
    #1;
    accel_x     = AccW'(x);
    accel_y     = AccW'(y);
    accel_valid = 1'b1;
    @(posedge clk);
    #1;
    accel_valid = 1'b0;
  endtask

  task automatic send_window(input int x0, input int x1, input int x2, input int x3,
                             input int y);
    exp_t e;
    e.x = (x0 + x1 + x2 + x3) >>> 2;
    e.y = (4 * y) >>> 2;
    exp_q.push_back(e);
    send_sample(x0, y);
    send_sample(x1, y);
    send_sample(x2, y);
    send_sample(x3, y);
  endtask

  task automatic wait_avg(input string name);
    bit   found;
    exp_t e;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (avg_ready === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    tests++;
    if (!found || exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s avg_ready: got no window result (queue=%0d)", name, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      tests++;
      if (tilt_x !== AccW'(e.x)) begin
        fails++;
        $display("FAIL %s tilt_x: got %0d expected %0d", name, tilt_x, e.x);
      end
      tests++;
      if (tilt_y !== AccW'(e.y)) begin
        fails++;
        $display("FAIL %s tilt_y: got %0d expected %0d", name, tilt_y, e.y);
      end
    end
  endtask

  task automatic wait_update(output bit ok);
    logic [3:0] prev;
    ok  = 1'b0;
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      prev = movement;
      @(negedge clk);
      gap++;
      if (update === 1'b1) begin
        ok          = 1'b1;
        move_before = prev;
        break;
      end
    end
  endtask

  // Skips one pulse so the pending decision has surely been loaded.
  task automatic check_move(input string name, input logic [3:0] exp_mv);
    bit ok1, ok2;
    wait_update(ok1);
    wait_update(ok2);
    tests++;
    if (!(ok1 && ok2)) begin
      fails++;
      $display("FAIL %s update: got no pulse within budget, expected one", name);
    end else if (movement !== exp_mv) begin
      fails++;
      $display("FAIL %s movement: got %b expected %b", name, movement, exp_mv);
    end
    tests++;
    if (move_before !== movement) begin
      fails++;
      $display("FAIL %s stable: got %b before pulse, expected %b", name, move_before, movement);
    end
  endtask

  task automatic test_reset();
    int first;
    reset       = 1'b1;
    accel_x     = '0;
    accel_y     = '0;
    accel_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({movement, update, tilt_x, tilt_y, avg_ready} !== '0) begin
      fails++;
      $display("FAIL reset_vals: got mv=%b up=%b tx=%0d ty=%0d rdy=%b expected all 0",
               movement, update, tilt_x, tilt_y, avg_ready);
    end
    reset = 1'b0;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (update === 1'b1) begin
        first = i;
        break;
      end
    end
    tests++;
    if (first != P) begin
      fails++;
      $display("FAIL first_update: got cycle %0d expected %0d", first, P);
    end
  endtask

  task automatic test_right();
    bit ok;
    send_window(200, 200, 200, 200, 0);
    wait_avg("right");
    check_move("right", 4'b1000);
    wait_update(ok);
    tests++;
    if (!ok || gap != P) begin
      fails++;
      $display("FAIL period: got %0d cycles expected %0d", gap, P);
    end
  endtask

  task automatic test_dead_zone();
    send_window(120, 120, 120, 120, 0);
    wait_avg("hold120");
    check_move("hold120", 4'b1000);
    send_window(90, 90, 90, 90, 0);
    wait_avg("drop90");
    check_move("drop90", 4'b0000);
    send_window(120, 120, 120, 120, 0);
    wait_avg("enter120");
    check_move("enter120", 4'b0000);
  endtask

  task automatic test_switch();
    send_window(-300, -300, -300, -300, -300);
    wait_avg("tie");
    check_move("tie", 4'b0001);
    send_window(-400, -400, -400, -400, -300);
    wait_avg("switch");
    check_move("switch", 4'b0100);
  endtask

  task automatic test_floor_extreme();
    send_window(-1, -1, -1, -2, 0);
    wait_avg("floor");
    check_move("floor", 4'b0000);
    send_window(-2048, -2048, -2048, -2048, 0);
    wait_avg("min");
    check_move("min", 4'b0100);
  endtask

  task automatic test_reversal();
    bit         ok1, ok2;
    logic [3:0] m1;
    send_window(0, 0, 0, 0, 300);
    wait_avg("down");
    check_move("down", 4'b0010);
    send_window(0, 0, 0, 0, -300);
    wait_avg("reverse");
    wait_update(ok1);
    m1 = movement;
    wait_update(ok2);
    tests++;
    if (!(ok1 && ok2) || m1 === 4'b0000) begin
      fails++;
      $display("FAIL reverse_gap: got %b between, expected no 0000", m1);
    end
    tests++;
    if (movement !== 4'b0001) begin
      fails++;
      $display("FAIL reverse: got %b expected 0001", movement);
    end
  endtask

  task automatic test_async_reset();
    int   base;
    exp_t e;
    send_window(200, 200, 200, 200, 0);
    wait_avg("pre_reset");
    check_move("pre_reset", 4'b1000);
    send_sample(200, 0);
    send_sample(200, 0);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({movement, update, tilt_x, tilt_y, avg_ready} !== '0) begin
      fails++;
      $display("FAIL async_reset: got mv=%b up=%b tx=%0d ty=%0d rdy=%b expected all 0",
               movement, update, tilt_x, tilt_y, avg_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    base  = avg_cnt;
    send_sample(200, 0);
    send_sample(200, 0);
    send_sample(200, 0);
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (avg_cnt != base) begin
      fails++;
      $display("FAIL partial_discard: got %0d windows expected 0", avg_cnt - base);
    end
    check_move("after_reset", 4'b0000);
    e.x = 200;
    e.y = 0;
    exp_q.push_back(e);
    send_sample(200, 0);
    wait_avg("refill");
    check_move("refill", 4'b1000);
  endtask

  initial begin
    test_reset();
    test_right();
    test_dead_zone();
    test_switch();
    test_floor_extreme();
    test_reversal();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
